// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit multi-cycle RISC CPU: opcodes, control-FSM states,
// datapath mux select codes and the control word driven by the control unit.
package cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_LUI  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_WB_ALU   = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_WB_IMM   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_HALT     = 4'd13
    } state_t;

    localparam logic [1:0] ALUSRCB_REG  = 2'b00;
    localparam logic [1:0] ALUSRCB_ONE  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM  = 2'b10;
    localparam logic [1:0] ALUSRCB_BOFF = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;
    localparam logic [1:0] WB_IMM    = 2'b11;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       iord;
        logic       mem_req;
        logic       mem_we;
        logic       alusrca_sel;
        logic [1:0] alusrcb_sel;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic [1:0] wb_sel;
        logic       reg_we;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    // Opcodes 0xA..0xE have no defined instruction.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= 4'hA) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decoder: maps the current FSM state (plus opcode,
// zero flag and memory ready) onto the datapath enables and mux selects.
module mc_ctrl_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Moore outputs per state; only FETCH and BRANCH gate an enable with an input.
    always_comb begin
        ctrl = '0;
        case (state)
            ST_RESET: begin
                ctrl = '0;
            end
            ST_FETCH: begin
                ctrl.mem_req     = 1'b1;
                ctrl.iord        = 1'b0;
                ctrl.alusrca_sel = 1'b0;
                ctrl.alusrcb_sel = ALUSRCB_ONE;
                ctrl.alu_op      = ALU_ADD;
                ctrl.pc_src      = PCSRC_ALU;
                ctrl.pc_we       = mem_ready;
                ctrl.ir_we       = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alusrca_sel = 1'b0;
                ctrl.alusrcb_sel = ALUSRCB_BOFF;
                ctrl.alu_op      = ALU_ADD;
                ctrl.illegal     = is_illegal_op(opcode);
            end
            ST_EXEC_R: begin
                ctrl.alusrca_sel = 1'b1;
                ctrl.alusrcb_sel = ALUSRCB_REG;
                ctrl.alu_op      = opcode[1:0];
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                ctrl.alusrca_sel = 1'b1;
                ctrl.alusrcb_sel = ALUSRCB_IMM;
                ctrl.alu_op      = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
            end
            ST_WB_ALU: begin
                ctrl.reg_we = 1'b1;
                ctrl.wb_sel = WB_ALUOUT;
            end
            ST_WB_MEM: begin
                ctrl.reg_we = 1'b1;
                ctrl.wb_sel = WB_MDR;
            end
            ST_WB_IMM: begin
                ctrl.reg_we = 1'b1;
                ctrl.wb_sel = WB_IMM;
            end
            ST_BRANCH: begin
                ctrl.alusrca_sel = 1'b1;
                ctrl.alusrcb_sel = ALUSRCB_REG;
                ctrl.alu_op      = ALU_SUB;
                ctrl.pc_src      = PCSRC_ALUOUT;
                ctrl.pc_we       = zero;
            end
            ST_JUMP: begin
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.pc_we  = 1'b1;
            end
            ST_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: state register, next-state sequencing with memory
// ready handshake, and the retired-instruction counter.
module mc_control_fsm
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        iord,
    output logic        mem_req,
    output logic        mem_we,
    output logic        alusrca_sel,
    output logic [1:0]  alusrcb_sel,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic [1:0]  wb_sel,
    output logic        reg_we,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic        retire_s;
    ctrl_t       ctrl_s;
    ctrl_t       ctrl_out_s;

    mc_ctrl_decode u_decode (
        .state     (state_q),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_s)
    );

    // Next-state selection; retire_s marks every transition that completes an instruction.
    always_comb begin
        state_d  = state_q;
        retire_s = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = ST_EXEC_R;
                    OP_ADDI:                       state_d = ST_EXEC_I;
                    OP_LW, OP_SW:                  state_d = ST_MEM_ADDR;
                    OP_BEQ:                        state_d = ST_BRANCH;
                    OP_JMP:                        state_d = ST_JUMP;
                    OP_LUI:                        state_d = ST_WB_IMM;
                    OP_HALT:                       state_d = ST_HALT;
                    default:                       state_d = ST_FETCH;
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: begin
                state_d = ST_WB_ALU;
            end
            ST_MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    state_d = ST_MEM_RD;
                end else begin
                    state_d = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                if (mem_ready) begin
                    state_d = ST_WB_MEM;
                end else begin
                    state_d = ST_MEM_RD;
                end
            end
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_d  = ST_FETCH;
                    retire_s = 1'b1;
                end else begin
                    state_d = ST_MEM_WR;
                end
            end
            ST_WB_ALU, ST_WB_MEM, ST_WB_IMM, ST_BRANCH, ST_JUMP: begin
                state_d  = ST_FETCH;
                retire_s = 1'b1;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Counter wraps naturally at 16 bits.
    always_comb begin
        if (retire_s) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // State and counter registers; reset abandons any in-flight memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Outputs are held at zero for as long as rst is asserted, even before the first edge.
    always_comb begin
        if (rst) begin
            ctrl_out_s  = '0;
            instr_count = 16'h0000;
        end else begin
            ctrl_out_s  = ctrl_s;
            instr_count = count_q;
        end
    end

    assign pc_we       = ctrl_out_s.pc_we;
    assign ir_we       = ctrl_out_s.ir_we;
    assign iord        = ctrl_out_s.iord;
    assign mem_req     = ctrl_out_s.mem_req;
    assign mem_we      = ctrl_out_s.mem_we;
    assign alusrca_sel = ctrl_out_s.alusrca_sel;
    assign alusrcb_sel = ctrl_out_s.alusrcb_sel;
    assign alu_op      = ctrl_out_s.alu_op;
    assign pc_src      = ctrl_out_s.pc_src;
    assign wb_sel      = ctrl_out_s.wb_sel;
    assign reg_we      = ctrl_out_s.reg_we;
    assign halted      = ctrl_out_s.halted;
    assign illegal     = ctrl_out_s.illegal;

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control unit for the 16-bit RISC CPU. It sits directly upstream of the datapath's 16-bit 4:1 select muxes and drives their 2-bit select lines: ALU operand B select and register write-back source select. It also drives PC, IR, memory and register-file enables. It is a Moore state machine that sequences each instruction through fetch/decode/execute/memory/write-back, with a ready handshake to memory and a retired-instruction counter.

## Interface
- No parameters; all encodings are fixed constants in the shared package.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  4  IR[15:12], valid from DECODE onward
- zero  in  1  ALU zero flag, combinational from datapath
- mem_ready  in  1  memory completes the current request this cycle
- pc_we  out  1  PC write enable
- ir_we  out  1  IR write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_req  out  1  memory request
- mem_we  out  1  memory write; only meaningful when mem_req = 1
- alusrca_sel  out  1  0 = PC, 1 = reg A
- alusrcb_sel  out  2  operand B mux: 00 = reg B, 01 = const 1, 10 = sext imm, 11 = branch offset
- alu_op  out  2  00 = add, 01 = sub, 10 = and, 11 = or
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- wb_sel  out  2  write-back mux: 00 = ALUOut, 01 = MDR, 10 = PC, 11 = imm<<8
- reg_we  out  1  register file write enable
- halted  out  1  high in HALT
- illegal  out  1  one-cycle pulse on an undefined opcode
- instr_count  out  16  retired-instruction counter

## Operation
Opcodes:
- 0–3 = ADD / SUB / AND / OR (R-type)
- 4 = ADDI, 5 = LW, 6 = SW, 7 = BEQ, 8 = JMP, 9 = LUI, F = HALT
- A–E are illegal.

Unlisted outputs are 0 in every state.

States and outputs:
- RESET: all outputs 0 → FETCH.
- FETCH: mem_req = 1, iord = 0, alusrca = 0, alusrcb = 01, add, pc_src = 00. pc_we = ir_we = mem_ready. Holds until mem_ready, then → DECODE.
- DECODE: alusrca = 0, alusrcb = 11, add (branch target into ALUOut).
  - → EXEC_R (0–3), EXEC_I (4), MEM_ADDR (5, 6), BRANCH (7), JUMP (8), WB_IMM (9), HALT (F).
  - Illegal opcode: pulse illegal, → FETCH, no retire.
- EXEC_R: alusrca = 1, alusrcb = 00, alu_op = opcode[1:0] → WB_ALU.
- EXEC_I: alusrca = 1, alusrcb = 10, add → WB_ALU.
- MEM_ADDR: alusrca = 1, alusrcb = 10, add → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_req = 1, iord = 1. Holds until mem_ready → WB_MEM.
- MEM_WR: mem_req = mem_we = iord = 1. Holds until mem_ready → FETCH (retire).
- WB_ALU: reg_we = 1, wb_sel = 00 → FETCH (retire).
- WB_MEM: reg_we = 1, wb_sel = 01 → FETCH (retire).
- WB_IMM: reg_we = 1, wb_sel = 11 → FETCH (retire).
- BRANCH: alusrca = 1, alusrcb = 00, sub, pc_src = 01, pc_we = zero → FETCH (retire).
- JUMP: pc_src = 10, pc_we = 1 → FETCH (retire).
- HALT: halted = 1. Absorbing; only rst exits.

instr_count:
- Increments by 1 on each retiring transition.
- 16-bit wrap: 0xFFFF → 0x0000.

## Timing
- State and instr_count are registers. Outputs are combinational from state, plus mem_ready and zero gating.
- While rst = 1, every output is forced to 0 combinationally, including in the reset cycle itself.
- On a rst edge: state = RESET, instr_count = 0, from any state including mid-memory wait. Any request dropped this way is abandoned.
- With mem_ready tied high, instruction latency (FETCH through last state) is:
  - 4 cycles: R-type, ADDI, SW
  - 5 cycles: LW
  - 3 cycles: BEQ, JMP, LUI
- Each cycle of mem_ready = 0 in FETCH, MEM_RD or MEM_WR adds one cycle. mem_req stays high and iord and mem_we stay stable throughout the wait.
- In FETCH, pc_we and ir_we assert only in the mem_ready cycle; never twice per fetch.
- After rst deasserts, FETCH begins one cycle later (the RESET state cycle).

## Structure
- Shared package cpu_pkg holds:
  - opcode constants
  - state encoding (localparam, 4 bits)
  - ALUSRCB_*, WB_*, ALU_*, PCSRC_* select encodings, shared with the datapath muxes
- One natural sub-module: mc_ctrl_decode, a purely combinational state/opcode → control-word decoder. The top holds the state register, next-state logic and counter.

## Test plan
- Reset: hold rst 3 cycles in mid-MEM_RD → all outputs 0 during rst. First cycle after release is RESET; the next is FETCH with mem_req = 1 and instr_count = 0.
- ADD (opcode 0), mem_ready = 1 → state sequence FETCH, DECODE, EXEC_R, WB_ALU. WB_ALU has reg_we = 1, wb_sel = 00. instr_count goes 0 → 1.
- LW with mem_ready low for 2 cycles in MEM_RD → 7-cycle instruction. mem_req and iord stay high across the wait. WB_MEM has wb_sel = 01.
- BEQ: zero = 1 → pc_we = 1, pc_src = 01. Repeat with zero = 0 → pc_we = 0. Both retire.
- Opcode 0xB → illegal pulse in DECODE, return to FETCH, instr_count unchanged. Opcode 0xF → halted stays 1 for 20 cycles until rst.
- Retire 65536 1-cycle-ready JMPs → instr_count wraps to 0x0000.
